// File: rtl/ipa_ctx_fetch_ctrl.sv
// ipa_ctx_fetch_ctrl
//
// Context-fetch and execution sequencer for the IPA cluster. On start it
// reads len_i context words from NB_BANKS GCM banks in parallel, taking
// priority over the DMA crossbar on every bank it reads. It concatenates the
// bank words (bank 0 in the MS slice) and streams them through a small FIFO to
// the CGRA configuration port. Once the last word is accepted it enables
// execution until the PEs report end of execution.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               one-cycle start pulse (ignored unless idle)
//   base_addr_i, len_i    first bank word address / context length, sampled on start
//   abort_i               cancel the current operation (no done_o)
//   gcm_req_o/addr_o      per-bank read request and word address
//   gcm_rdata_i           per-bank read data, valid one cycle after the request
//   dma_stall_o           blocks DMA crossbar access to each bank being read
//   ctx_valid_o/ready_i   context word handshake
//   ctx_data_o/idx_o      context word and its index within the context
//   exec_en_o             CGRA execute enable
//   end_exec_i            per-PE end-of-execution flags
//   busy_o, done_o        operation in progress / one-cycle completion pulse
//
// Handshake: a context word moves in every cycle where ctx_valid_o and
// ctx_ready_i are both high. While ctx_valid_o is high and ctx_ready_i is low,
// ctx_data_o and ctx_idx_o hold their values.
//
// Build option: define IPA_CTX_EXEC_ALL_EN to require every PE to have raised
// end_exec_i (accumulated in a sticky mask) before execution counts as
// complete. Without it, any single end_exec_i bit completes execution.

module ipa_ctx_fetch_ctrl #(
  parameter int NB_BANKS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_MEM_WIDTH = 12,
  parameter int LEN_WIDTH      = 16,
  parameter int NB_PE          = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic [ADDR_MEM_WIDTH-1:0]          base_addr_i,
  input  logic [LEN_WIDTH-1:0]               len_i,
  input  logic                               abort_i,
  output logic [NB_BANKS-1:0]                gcm_req_o,
  output logic [NB_BANKS*ADDR_MEM_WIDTH-1:0] gcm_addr_o,
  input  logic [NB_BANKS*DATA_WIDTH-1:0]     gcm_rdata_i,
  output logic [NB_BANKS-1:0]                dma_stall_o,
  output logic                               ctx_valid_o,
  input  logic                               ctx_ready_i,
  output logic [NB_BANKS*DATA_WIDTH-1:0]     ctx_data_o,
  output logic [LEN_WIDTH-1:0]               ctx_idx_o,
  output logic                               exec_en_o,
  input  logic [NB_PE-1:0]                   end_exec_i,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int CTXW = NB_BANKS * DATA_WIDTH;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_EXEC  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [ADDR_MEM_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      issued_q, issued_d;
  logic                      inflight_q, inflight_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [LEN_WIDTH-1:0]      idx_q, idx_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic [CTXW-1:0]           mem_q [FIFO_DEPTH];

`ifdef IPA_CTX_EXEC_ALL_EN
  logic [NB_PE-1:0]          mask_q, mask_d;
  logic [NB_PE-1:0]          mask_acc;
`endif

  logic                      push, pop, flush, issue, last_issue;
  logic                      credit_ok, exec_done, zero_start;
  logic [CW:0]               occupancy;
  logic [ADDR_MEM_WIDTH-1:0] cur_addr;
  logic [CTXW-1:0]           push_word;

  // Reorder bank words so that bank 0 lands in the most significant slice.
  always_comb begin
    push_word = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      push_word[(NB_BANKS-1-b)*DATA_WIDTH +: DATA_WIDTH] = gcm_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Slots already filled plus the read still in flight must leave room for
  // one more word; this credit check is what keeps the FIFO from overflowing.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = occupancy < DEPTH_C;

  assign flush      = abort_i && (state_q != ST_IDLE);
  assign issue      = (state_q == ST_FETCH) && !abort_i && (issued_q < len_q) && credit_ok;
  assign last_issue = issue && (issued_q == len_q - LEN_WIDTH'(1));
  assign push       = inflight_q;
  assign pop        = (count_q != '0) && ctx_ready_i;
  assign zero_start = (state_q == ST_IDLE) && start_i && !abort_i && (len_i == '0);
  assign cur_addr   = base_q + ADDR_MEM_WIDTH'(issued_q);

`ifdef IPA_CTX_EXEC_ALL_EN
  // Include the current cycle's flags so completion is seen without delay.
  assign mask_acc  = mask_q | end_exec_i;
  assign exec_done = &mask_acc;
`else
  assign exec_done = |end_exec_i;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    idx_d      = idx_q + LEN_WIDTH'(pop);
    done_d     = 1'b0;
`ifdef IPA_CTX_EXEC_ALL_EN
    mask_d     = mask_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i && (len_i != '0)) begin
          base_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
          idx_d    = '0;
          state_d  = ST_FETCH;
        end else if (zero_start) begin
          done_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last read landed and the CGRA took every word.
        if (!inflight_q && (count_q == '0)) begin
          state_d = ST_EXEC;
`ifdef IPA_CTX_EXEC_ALL_EN
          mask_d  = '0;
`endif
        end
      end
      ST_EXEC: begin
`ifdef IPA_CTX_EXEC_ALL_EN
        mask_d = mask_acc;
`endif
        if (exec_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d    = ST_IDLE;
      issued_d   = '0;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      idx_d      = '0;
      done_d     = 1'b0;
`ifdef IPA_CTX_EXEC_ALL_EN
      mask_d     = '0;
`endif
    end

    busy_d = (state_d != ST_IDLE) || zero_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef IPA_CTX_EXEC_ALL_EN
      mask_q     <= '0;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef IPA_CTX_EXEC_ALL_EN
      mask_q     <= mask_d;
`endif
      if (push && !flush) begin
        mem_q[wr_ptr_q] <= push_word;
      end
    end
  end

  assign gcm_req_o   = {NB_BANKS{issue}};
  assign dma_stall_o = {NB_BANKS{issue}};
  assign gcm_addr_o  = {NB_BANKS{cur_addr}};
  assign ctx_valid_o = (count_q != '0);
  assign ctx_data_o  = mem_q[rd_ptr_q];
  assign ctx_idx_o   = idx_q;
  assign exec_en_o   = (state_q == ST_EXEC);
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ipa_ctx_fetch_ctrl.sv
module tb_ipa_ctx_fetch_ctrl;

  localparam int NB    = 2;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int LW    = 16;
  localparam int NPE   = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start_i = 1'b0;
  logic [AW-1:0]     base_addr_i = '0;
  logic [LW-1:0]     len_i = '0;
  logic              abort_i = 1'b0;
  logic [NB-1:0]     gcm_req_o;
  logic [NB*AW-1:0]  gcm_addr_o;
  logic [NB*DW-1:0]  gcm_rdata_i = '0;
  logic [NB-1:0]     dma_stall_o;
  logic              ctx_valid_o;
  logic              ctx_ready_i = 1'b1;
  logic [NB*DW-1:0]  ctx_data_o;
  logic [LW-1:0]     ctx_idx_o;
  logic              exec_en_o;
  logic [NPE-1:0]    end_exec_i = '0;
  logic              busy_o;
  logic              done_o;

  ipa_ctx_fetch_ctrl #(
    .NB_BANKS(NB), .DATA_WIDTH(DW), .ADDR_MEM_WIDTH(AW),
    .LEN_WIDTH(LW), .NB_PE(NPE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .abort_i(abort_i), .gcm_req_o(gcm_req_o), .gcm_addr_o(gcm_addr_o),
    .gcm_rdata_i(gcm_rdata_i), .dma_stall_o(dma_stall_o), .ctx_valid_o(ctx_valid_o),
    .ctx_ready_i(ctx_ready_i), .ctx_data_o(ctx_data_o), .ctx_idx_o(ctx_idx_o),
    .exec_en_o(exec_en_o), .end_exec_i(end_exec_i), .busy_o(busy_o), .done_o(done_o)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [63:0]   exp_q[$];
  logic [LW-1:0] exp_idx_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [11:0]   salt = '0;
  int req_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  bit hold_v = 0;
  logic [63:0]   hold_data;
  logic [LW-1:0] hold_idx;
  int stall_n = 0;
  bit rand_ready = 0;

  // Memory content of bank b at word address a.
  function automatic logic [31:0] data_of(input int b, input logic [AW-1:0] a);
    return 32'hA000_0000 + 32'(b) * 32'h1000_0000 + {8'h00, salt, a};
  endfunction

  // Expected transfers: every word of the context, in order, bank 0 in the MS half.
  task automatic model_load(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back({data_of(0, a), data_of(1, a)});
      exp_idx_q.push_back(LW'(i));
    end
  endtask

  // GCM responder: returns data one cycle after each request.
  initial begin
    logic pend_v;
    logic [AW-1:0] pa0, pa1;
    forever begin
      @(negedge clk);
      pend_v = gcm_req_o[0];
      pa0 = gcm_addr_o[AW-1:0];
      pa1 = gcm_addr_o[2*AW-1:AW];
      @(posedge clk);
      #1;
      if (pend_v) gcm_rdata_i = {data_of(1, pa1), data_of(0, pa0)};
      else        gcm_rdata_i = {$urandom, $urandom};
    end
  end

  // Ready driver: forced stalls, otherwise random or always-ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_n > 0) begin
        ctx_ready_i = 1'b0;
        stall_n--;
      end else begin
        ctx_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: requests, credit bound, stream order, hold stability.
  initial begin
    logic [AW-1:0] ma;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done_o) done_cnt++;
        if (gcm_req_o != '0) begin
          chk("req_all_banks", 64'(gcm_req_o), 64'({NB{1'b1}}));
          chk("dma_stall", 64'(dma_stall_o), 64'(gcm_req_o));
          if (exp_addr_q.size() == 0) begin
            chk("unexpected_req", 64'(gcm_req_o), 64'(0));
          end else begin
            ma = exp_addr_q.pop_front();
            chk("gcm_addr", 64'(gcm_addr_o), 64'({ma, ma}));
          end
          req_cnt++;
          chk("credit_bound", 64'(req_cnt - acc_cnt <= DEPTH), 64'(1));
        end
        if (hold_v) begin
          chk("hold_valid", 64'(ctx_valid_o), 64'(1));
          chk("hold_data", ctx_data_o, hold_data);
          chk("hold_idx", 64'(ctx_idx_o), 64'(hold_idx));
        end
        hold_v = 0;
        if (ctx_valid_o && ctx_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ctx", 64'(ctx_valid_o), 64'(0));
          end else begin
            chk("ctx_data", ctx_data_o, exp_q.pop_front());
            chk("ctx_idx", 64'(ctx_idx_o), 64'(exp_idx_q.pop_front()));
          end
          acc_cnt++;
        end else if (ctx_valid_o) begin
          hold_v = 1;
          hold_data = ctx_data_o;
          hold_idx = ctx_idx_o;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [AW-1:0] base, input logic [LW-1:0] len);
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; len_i = len;
    @(posedge clk); #1;
    start_i = 1'b0; base_addr_i = AW'($urandom); len_i = LW'($urandom);
  endtask

  task automatic begin_op(input logic [AW-1:0] base, input int len);
    req_cnt = 0; acc_cnt = 0; done_cnt = 0;
    model_load(base, len);
    pulse_start(base, LW'(len));
    // End-of-exec noise outside EXEC must be ignored; a second start too.
    end_exec_i = NPE'($urandom);
    pulse_start(AW'($urandom), LW'($urandom_range(1, 9)));
  endtask

  task automatic finish_op(input bit directed);
    int cyc;
    int step;
    logic [NPE-1:0] acc;
    logic [NPE-1:0] v;
    bit comp;
    cyc = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    chk("stream_timeout", 64'(cyc < 3000), 64'(1));
    end_exec_i = '0;
    cyc = 0;
    while (!exec_en_o && cyc < 10) begin
      @(negedge clk); cyc++;
    end
    chk("exec_en_on", 64'(exec_en_o), 64'(1));
    chk("busy_exec", 64'(busy_o), 64'(1));
    chk("valid_in_exec", 64'(ctx_valid_o), 64'(0));
    chk("no_early_done", 64'(done_cnt), 64'(0));
    acc = '0; comp = 0; step = 0;
    while (!comp && step < 12) begin
      @(posedge clk); #1;
      if (directed) begin
        v = (step == 0) ? 16'h0000 : (step == 1) ? 16'h00FF : 16'hFF00;
      end else if (step >= 8) begin
        v = 16'hFFFF;
      end else begin
        case ($urandom_range(0, 2))
          0: v = 16'h0000;
          1: v = 16'h0004;
          default: v = NPE'($urandom) & 16'h7FFF;
        endcase
      end
      end_exec_i = v;
      acc = acc | v;
`ifdef IPA_CTX_EXEC_ALL_EN
      comp = &acc;
`else
      comp = |v;
`endif
      @(posedge clk);
      @(negedge clk);
      chk("done_pulse", 64'(done_o), 64'(comp));
      chk("exec_en_track", 64'(exec_en_o), 64'(!comp));
      chk("busy_track", 64'(busy_o), 64'(!comp));
      step++;
    end
    chk("exec_timeout", 64'(comp), 64'(1));
    @(posedge clk); #1;
    end_exec_i = '0;
    @(negedge clk);
    chk("done_one_cycle", 64'(done_o), 64'(0));
    chk("idle_busy", 64'(busy_o), 64'(0));
    chk("done_count", 64'(done_cnt), 64'(1));
  endtask

  task automatic run_op(input logic [AW-1:0] base, input int len, input bit directed);
    begin_op(base, len);
    finish_op(directed);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    #12;
    chk("rst_req", 64'(gcm_req_o), 64'(0));
    chk("rst_valid", 64'(ctx_valid_o), 64'(0));
    chk("rst_idx", 64'(ctx_idx_o), 64'(0));
    chk("rst_data", ctx_data_o, 64'(0));
    chk("rst_busy_done_exec", 64'({busy_o, done_o, exec_en_o}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Directed basic run.
    salt = '0;
    run_op(12'h010, 4, 1'b1);

    // Back-pressure: only DEPTH reads may issue while ready is low.
    stall_n = 20;
    begin_op(12'h010, 8);
    repeat (8) @(negedge clk);
    chk("stall_reqs", 64'(req_cnt), 64'(DEPTH));
    finish_op(1'b0);

    // Address wrap.
    run_op(12'hFFE, 3, 1'b0);

    // Zero length: no reads, done one cycle after start.
    done_cnt = 0;
    pulse_start(12'h123, 16'd0);
    @(negedge clk);
    chk("zl_done", 64'(done_o), 64'(1));
    chk("zl_busy", 64'(busy_o), 64'(1));
    chk("zl_exec", 64'(exec_en_o), 64'(0));
    @(negedge clk);
    chk("zl_done_off", 64'({done_o, busy_o, exec_en_o}), 64'(0));

    // Abort during fetch after 2 of 8 reads.
    salt = 12'($urandom);
    req_cnt = 0; acc_cnt = 0; done_cnt = 0;
    stall_n = 40;
    model_load(12'h200, 8);
    pulse_start(12'h200, 16'd8);
    cyc = 0;
    while (req_cnt < 2 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    chk("abort_reqs", 64'(req_cnt), 64'(2));
    @(posedge clk); #1; abort_i = 1'b1;
    @(posedge clk); #1; abort_i = 1'b0;
    exp_q.delete(); exp_idx_q.delete(); exp_addr_q.delete();
    hold_v = 0;
    @(negedge clk);
    chk("abort_valid", 64'(ctx_valid_o), 64'(0));
    chk("abort_req", 64'(gcm_req_o), 64'(0));
    chk("abort_busy_exec", 64'({busy_o, exec_en_o}), 64'(0));
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    stall_n = 0;
    run_op(12'h300, 2, 1'b0);

    // Abort together with start in idle: nothing starts.
    req_cnt = 0; done_cnt = 0;
    @(posedge clk); #1; start_i = 1'b1; abort_i = 1'b1; len_i = 16'd5;
    @(posedge clk); #1; start_i = 1'b0; abort_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_start_busy", 64'(busy_o), 64'(0));
    chk("abort_start_reqs", 64'(req_cnt + done_cnt), 64'(0));

    // Reset in the middle of a fetch.
    stall_n = 20;
    model_load(12'h050, 8);
    pulse_start(12'h050, 16'd8);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 64'({gcm_req_o, ctx_valid_o, busy_o, exec_en_o, done_o}), 64'(0));
    chk("mid_rst_idx", 64'(ctx_idx_o), 64'(0));
    exp_q.delete(); exp_idx_q.delete(); exp_addr_q.delete();
    hold_v = 0; stall_n = 0;
    @(negedge clk); rst_n = 1'b1;

    // Randomized runs with random ready.
    rand_ready = 1;
    for (int r = 0; r < 12; r++) begin
      salt = 12'($urandom);
      run_op((r % 4 == 0) ? AW'($urandom_range(4088, 4095)) : AW'($urandom),
             $urandom_range(1, 10), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
